// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared lookahead constants, group helper and propagate/generate type
package cla_pkg;

  localparam int GROUP_W = 4;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  function automatic int group_count(input int width);
    return width / GROUP_W;
  endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// rtl/cla_pipe_adder_if.sv - operand/result handshake bundle of the pipelined adder
interface cla_pipe_adder_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/cla_group4.sv
// rtl/cla_group4.sv - combinational 4-bit carry-lookahead group
module cla_group4
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] sum,
  output logic               cout,
  output logic               c3
);

  pg_t [GROUP_W-1:0] w_pg;
  logic [GROUP_W:0]  w_c;

  always_comb begin
    for (int i = 0; i < GROUP_W; i++) begin
      w_pg[i].p = a[i] ^ b[i];
      w_pg[i].g = a[i] & b[i];
    end
  end

  // Every carry is flattened to sum-of-products from the group carry-in
  assign w_c[0] = cin;
  assign w_c[1] = w_pg[0].g | (w_pg[0].p & cin);
  assign w_c[2] = w_pg[1].g | (w_pg[1].p & w_pg[0].g)
                | (w_pg[1].p & w_pg[0].p & cin);
  assign w_c[3] = w_pg[2].g | (w_pg[2].p & w_pg[1].g)
                | (w_pg[2].p & w_pg[1].p & w_pg[0].g)
                | (w_pg[2].p & w_pg[1].p & w_pg[0].p & cin);
  assign w_c[4] = w_pg[3].g | (w_pg[3].p & w_pg[2].g)
                | (w_pg[3].p & w_pg[2].p & w_pg[1].g)
                | (w_pg[3].p & w_pg[2].p & w_pg[1].p & w_pg[0].g)
                | (w_pg[3].p & w_pg[2].p & w_pg[1].p & w_pg[0].p & cin);

  always_comb begin
    for (int i = 0; i < GROUP_W; i++) begin
      sum[i] = w_pg[i].p ^ w_c[i];
    end
  end

  assign cout = w_c[4];
  assign c3   = w_c[3];

endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-lookahead add/subtract, one operand slice per stage
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  cla_pipe_adder_if.slave bus
);

  localparam int S = WIDTH / STAGES;
  localparam int G = group_count(S);

  if (STAGES < 1 || (WIDTH % (GROUP_W * STAGES)) != 0) begin : g_param_chk
    $error("cla_pipe_adder: WIDTH must be a multiple of 4*STAGES");
  end

  logic w_adv;

  assign w_adv        = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand B still to be added: only the slices from k upward travel on
    localparam int YW = WIDTH - k * S;

    logic             w_vld;
    logic [WIDTH-1:0] w_x;
    logic [YW-1:0]    w_y;
    logic             w_cin;
    logic [G:0]       w_gc;
    logic [G-1:0]     w_c3;
    logic [S-1:0]     w_s;
    logic [WIDTH-1:0] w_x_nxt;

    logic             r_vld;
    logic [WIDTH-1:0] r_x;
    logic             r_c;

    if (k == 0) begin : g_src
      assign w_vld = bus.in_valid;
      assign w_x   = bus.a;
      assign w_y   = bus.b ^ {WIDTH{bus.sub}};
      assign w_cin = bus.cin ^ bus.sub;
    end else begin : g_src
      assign w_vld = g_stage[k-1].r_vld;
      assign w_x   = g_stage[k-1].r_x;
      assign w_y   = g_stage[k-1].g_fwd.r_y;
      assign w_cin = g_stage[k-1].r_c;
    end

    assign w_gc[0] = w_cin;

    for (genvar g = 0; g < G; g++) begin : g_grp
      cla_group4 u_grp (
        .a    (w_x[k*S + GROUP_W*g +: GROUP_W]),
        .b    (w_y[GROUP_W*g +: GROUP_W]),
        .cin  (w_gc[g]),
        .sum  (w_s[GROUP_W*g +: GROUP_W]),
        .cout (w_gc[g+1]),
        .c3   (w_c3[g])
      );
    end

    // r_x carries finished sum bits below the current slice and raw A bits above it
    always_comb begin
      w_x_nxt            = w_x;
      w_x_nxt[k*S +: S]  = w_s;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_x   <= '0;
        r_c   <= 1'b0;
      end else if (w_adv) begin
        r_vld <= w_vld;
        r_x   <= w_x_nxt;
        r_c   <= w_gc[G];
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [YW-S-1:0] r_y;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_y <= '0;
        end else if (w_adv) begin
          r_y <= w_y[YW-1:S];
        end
      end
    end else begin : g_last
      logic r_ovf;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= w_c3[G-1] ^ w_gc[G];
        end
      end
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].r_vld;
  assign bus.sum       = g_stage[STAGES-1].r_x;
  assign bus.cout      = g_stage[STAGES-1].r_c;
  assign bus.ovf       = g_stage[STAGES-1].g_last.r_ovf;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - directed and randomized scoreboard bench for cla_pipe_adder
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  logic rst_d;
  logic rst_r;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   done [4];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Integer arithmetic view: {ovf, cout, sum} for a w-bit add/subtract
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic sub, input int w);
    logic [63:0]        mask;
    logic signed [67:0] ua, ub, sa, sb, us, ss, lim, ci;
    logic               co, ov;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    ci   = cin ? 68'sd1 : 68'sd0;
    ua   = {4'b0, a & mask};
    ub   = {4'b0, b & mask};
    lim  = 68'sd1 <<< (w - 1);
    sa   = a[w-1] ? ua - (lim <<< 1) : ua;
    sb   = b[w-1] ? ub - (lim <<< 1) : ub;
    us   = sub ? ua - ub - ci : ua + ub + ci;
    ss   = sub ? sa - sb - ci : sa + sb + ci;
    co   = sub ? (us >= 0) : (us >= (lim <<< 1));
    ov   = (ss >= lim) || (ss < -lim);
    return {ov, co, us[63:0] & mask};
  endfunction

  cla_pipe_adder_if #(.WIDTH(32)) dif ();

  cla_pipe_adder #(.WIDTH(32), .STAGES(2)) u_dut (
    .clk (clk),
    .rst (rst_d),
    .bus (dif)
  );

  for (genvar i = 0; i < 4; i++) begin : g_rnd
    localparam int W  = (i == 2) ? 64 : (i == 3) ? 16 : 32;
    localparam int S  = (i == 0) ? 1 : (i == 1) ? 2 : 4;
    localparam int NB = 2500;

    cla_pipe_adder_if #(.WIDTH(W)) rif ();

    cla_pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk (clk),
      .rst (rst_r),
      .bus (rif)
    );

    logic [65:0] q[$];

    initial begin
      string       tag;
      logic [63:0] ra, rb, am, bm, s64;
      logic        rc, rs;
      int          sent, cyc;
      tag = $sformatf("rnd_w%0d_s%0d", W, S);
      rif.in_valid  = 1'b0;
      rif.a         = '0;
      rif.b         = '0;
      rif.cin       = 1'b0;
      rif.sub       = 1'b0;
      rif.out_ready = 1'b0;
      sent = 0;
      cyc  = 0;
      wait (rst_r === 1'b0);
      @(posedge clk);
      while ((sent < NB || q.size() > 0) && cyc < 20000) begin
        #1;
        ra = {$urandom(), $urandom()};
        rb = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
          0: ra = '1;
          1: rb = '1;
          2: rb = '0;
          default: ;
        endcase
        am = '0;
        bm = '0;
        am[W-1:0] = ra[W-1:0];
        bm[W-1:0] = rb[W-1:0];
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        rif.in_valid  = (sent < NB) && ($urandom_range(0, 3) != 0);
        rif.a         = am[W-1:0];
        rif.b         = bm[W-1:0];
        rif.cin       = rc;
        rif.sub       = rs;
        rif.out_ready = (sent >= NB) || ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (rif.out_valid && rif.out_ready) begin
          s64 = '0;
          s64[W-1:0] = rif.sum;
          if (q.size() == 0) check({tag, "_extra"}, 1, 0);
          else check(tag, {rif.ovf, rif.cout, s64}, q.pop_front());
        end
        if (rif.in_valid && rif.in_ready) begin
          q.push_back(model(am, bm, rc, rs, W));
          sent++;
        end
        @(posedge clk);
        cyc++;
      end
      rif.in_valid = 1'b0;
      check({tag, "_sent"}, sent, NB);
      check({tag, "_drain"}, q.size(), 0);
      done[i] = 1'b1;
    end
  end

  task automatic pack_out(output logic [65:0] o);
    o = {dif.ovf, dif.cout, 32'h0, dif.sum};
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input logic [65:0] exp);
    logic [65:0] o;
    dif.in_valid  = 1'b1;
    dif.a         = a;
    dif.b         = b;
    dif.cin       = cin;
    dif.sub       = sub;
    dif.out_ready = 1'b1;
    @(posedge clk);
    #1 dif.in_valid = 1'b0;
    check({tag, "_early"}, dif.out_valid, 0);
    @(posedge clk);
    #1;
    check({tag, "_vld"}, dif.out_valid, 1);
    pack_out(o);
    check(tag, o, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [65:0] o, held;
    logic [65:0] q5[$];
    logic [31:0] ta, tb;
    logic        tc, ts, held_v, rdy, seen;
    int          sent, got;
    bit          all_done;

    rst_d = 1'b1;
    rst_r = 1'b1;
    dif.in_valid  = 1'b0;
    dif.a         = '0;
    dif.b         = '0;
    dif.cin       = 1'b0;
    dif.sub       = 1'b0;
    dif.out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out_valid", dif.out_valid, 0);
    pack_out(o);
    check("rst_outputs", o, 66'h0);
    check("rst_in_ready", dif.in_ready, 1);
    @(negedge clk);
    rst_d = 1'b0;
    rst_r = 1'b0;
    @(posedge clk);
    #1;

    directed("carry_cross", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, {1'b0, 1'b1, 64'h0});
    directed("sub_neg",     32'h5, 32'h7, 1'b0, 1'b1, {1'b0, 1'b0, 64'hFFFF_FFFE});
    directed("sub_ovf",     32'h8000_0000, 32'h1, 1'b0, 1'b1, {1'b1, 1'b1, 64'h7FFF_FFFF});
    directed("add_ovf",     32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {1'b1, 1'b0, 64'h8000_0000});

    sent   = 0;
    got    = 0;
    held_v = 1'b0;
    held   = '0;
    for (int c = 0; c < 40 && got < 10; c++) begin
      ta  = $urandom();
      tb  = $urandom();
      tc  = 1'($urandom_range(0, 1));
      ts  = 1'($urandom_range(0, 1));
      rdy = !(c >= 3 && c <= 5);
      dif.in_valid  = (sent < 10);
      dif.a         = ta;
      dif.b         = tb;
      dif.cin       = tc;
      dif.sub       = ts;
      dif.out_ready = rdy;
      @(negedge clk);
      check("bb_in_ready", dif.in_ready, rdy);
      pack_out(o);
      if (held_v) check("bb_hold", o, held);
      held_v = dif.out_valid && !dif.out_ready;
      held   = o;
      if (dif.out_valid && dif.out_ready) begin
        if (q5.size() == 0) check("bb_extra", 1, 0);
        else check("bb_result", o, q5.pop_front());
        got++;
      end
      if (dif.in_valid && dif.in_ready) begin
        q5.push_back(model({32'h0, ta}, {32'h0, tb}, tc, ts, 32));
        sent++;
      end
      @(posedge clk);
      #1;
    end
    dif.in_valid = 1'b0;
    check("bb_count", got, 10);

    dif.out_ready = 1'b1;
    dif.in_valid  = 1'b1;
    dif.a         = 32'h1234_5678;
    dif.b         = 32'h1111_1111;
    @(posedge clk);
    #1 dif.a = 32'hFFFF_0000;
    @(posedge clk);
    #1 dif.in_valid = 1'b0;
    check("rst_pre_valid", dif.out_valid, 1);
    rst_d = 1'b1;
    #1;
    check("rst_async", dif.out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    rst_d = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seen = seen | dif.out_valid;
    end
    check("rst_no_stale", seen, 0);

    all_done = 1'b0;
    for (int c = 0; c < 40000 && !all_done; c++) begin
      @(posedge clk);
      all_done = done[0] && done[1] && done[2] && done[3];
    end
    check("rnd_finished", all_done, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
